tensor_feeder_sv: RTL and testbench
===================================

// Module: tensor_feeder_sv
// PURPOSE
//  Operand staging/sequencing front end for systolic_array_sv (SIZE x SIZE).
//  Buffers matrix A (per row) and B (per column) in SIZE+SIZE sync FIFOs.
//  On start, streams k_len operands per lane with diagonal skew (lane i delayed i cycles).
//  Drives the array's load_en/mult_en/acc_en and reports done; sits between host write port and array.
// PARAMETERS
//  DATAWIDTH  14  operand width (bits)
//  SIZE       8   array dimension = number of A lanes = number of B lanes (>=2)
//  DEPTH      16  entries per lane FIFO; max k_len (power of 2)
//  ARR_LAT    1   array internal MAC latency, added to drain time
// PORTS
//  clk        in   1                  clock, rising edge
//  reset      in   1                  synchronous, active-low (0 = reset)
//  wen        in   1                  write one operand
//  wsel_b     in   1                  0: target A lane FIFOs, 1: B lane FIFOs
//  wlane      in   $clog2(SIZE)       lane index for write
//  data_in    in   DATAWIDTH          write operand
//  start      in   1                  begin a tile (sampled only in IDLE)
//  k_len      in   $clog2(DEPTH+1)    operands per lane for this tile
//  a_out      out  SIZE*DATAWIDTH     skewed A lanes, lane i at [i*DATAWIDTH +: DATAWIDTH]
//  b_out      out  SIZE*DATAWIDTH     skewed B lanes, same packing
//  load_en    out  1                  clears array accumulators
//  mult_en    out  1                  array multiply enable
//  acc_en     out  1                  array accumulate enable
//  busy       out  1                  1 in any state except IDLE
//  done       out  1                  1-cycle pulse, tile result valid in array
//  err        out  1                  1-cycle pulse, start rejected
//  overflow   out  1                  sticky: a write hit a full FIFO
// BEHAVIOUR
//  Reset (reset==0 at clk edge): all FIFOs emptied, skew regs zeroed, state IDLE;
//   all outputs 0. Reset mid-tile aborts immediately, no done pulse.
//  Writes: accepted in any state; wen to full FIFO dropped, overflow<=1 until reset.
//   wlane >= SIZE: write dropped, no flag. Write and read same FIFO same cycle both occur.
//  FSM: IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
//   IDLE: start && k_len!=0 && every lane FIFO count >= k_len -> LOAD; start otherwise
//    -> err=1 next cycle, stay IDLE. start outside IDLE ignored.
//   LOAD: 1 cycle, load_en=1; latches k_len into internal kcnt.
//   STREAM: exactly k_len cycles; every A and B FIFO popped once per cycle.
//   DRAIN: 2*(SIZE-1)+ARR_LAT cycles; no pops; skew pipes flush zeros.
//   DONE: 1 cycle, done=1.
//  mult_en=acc_en=1 in STREAM and DRAIN, else 0.
//  Skew: lane i passes through i registers (lane 0 combinational from FIFO q reg);
//   registered a_out/b_out; a popped element appears on lane 0 one cycle after pop.
//   Non-streamed slots carry 0 (zero-insertion, so MAC of bubbles adds 0).
//  FIFO: registered q, 1-cycle read latency, pointers wrap mod DEPTH, count 0..DEPTH.
//  Tile cycle count from start sample to done: 1 + 1 + k_len + 2*(SIZE-1)+ARR_LAT.
//  No arithmetic on data; counters sized $clog2(DEPTH+1) and $clog2(2*SIZE+ARR_LAT+1).
// STRUCTURE
//  tensor_pkg: typedef enum logic[2:0] {IDLE,LOAD,STREAM,DRAIN,DONE} feeder_state_t;
//   localparam DRAIN_CYC function of SIZE, ARR_LAT; operand typedef logic[DATAWIDTH-1:0].
//  Sub-module tensor_lane_fifo (sync FIFO: wen/ren/data/q/count/full/empty, sync
//   active-low reset), instantiated 2*SIZE times by generate; skew pipes and FSM inline.
// TESTING
//  1 Reset: hold reset=0 3 cycles after random writes -> all outputs 0, start(k=1) -> err.
//  2 SIZE=4, load A=I4, B=[1..16] row-major, k_len=4 -> done at cycle 2+4+6+ARR_LAT,
//    a_out lane 2 shows 0,0,A[2][0] at cycles 1..3 of STREAM+1; array result = B.
//  3 k_len=5 with one lane holding 4 entries -> err pulse, busy stays 0, FIFO counts unchanged.
//  4 Write 17 operands to A lane 0 (DEPTH=16) -> overflow=1, count=16, 17th discarded.
//  5 Pulse start during STREAM and write B lane 3 during STREAM -> start ignored, write stored.
//  6 Assert reset=0 mid-DRAIN -> next cycle busy=0, done never pulses, outputs 0.

Source files
------------

// File: rtl/tensor_feeder_sv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tensor_feeder_sv_pkg
// Brief    : Shared types and helpers for the systolic-array operand feeder:
//            FSM state encoding, default operand type and drain-length helper.
// Revision : 1.0 - initial release
// ============================================================================
package tensor_feeder_sv_pkg;

  // Feeder sequencing states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

  // Default operand width and matching operand type.
  localparam int C_DATAWIDTH = 14;
  typedef logic [C_DATAWIDTH-1:0] operand_t;

  // Cycles needed after the last pop for the most-skewed lane to reach the
  // far corner of the array (SIZE-1 skew + SIZE-1 hops) plus the MAC latency.
  function automatic int drain_cycles(input int size, input int arr_lat);
    return 2 * (size - 1) + arr_lat;
  endfunction

endpackage : tensor_feeder_sv_pkg
`default_nettype wire

// File: rtl/tensor_feeder_sv_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tensor_feeder_sv_lane_fifo
// Brief    : Single-lane synchronous FIFO with a registered read port
//            (one-cycle read latency), occupancy count and full/empty flags.
//            Writes to a full FIFO are dropped; push and pop may coincide.
// Revision : 1.0 - initial release
// ============================================================================
module tensor_feeder_sv_lane_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,     // synchronous, active-low
  input  logic                       i_wen,
  input  logic                       i_ren,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_q,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full FIFO refuses the write even if it is being popped this cycle.
  assign w_push  = i_wen && !w_full;
  assign w_pop   = i_ren && !w_empty;

  // Storage array: only slots between read and write pointer are ever read,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers, occupancy and the registered read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_q     <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_q    <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_q     = r_q;
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule : tensor_feeder_sv_lane_fifo
`default_nettype wire

// File: rtl/tensor_feeder_sv.sv
`default_nettype none
// ============================================================================
// Module   : tensor_feeder_sv
// Brief    : Operand staging and sequencing front end for a SIZE x SIZE
//            systolic array. Buffers A rows and B columns in per-lane FIFOs,
//            streams k_len operands per lane with diagonal skew, drives the
//            array enables and reports done / err / overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tensor_feeder_sv
  import tensor_feeder_sv_pkg::*;
#(
  parameter int DATAWIDTH = 14,
  parameter int SIZE      = 8,
  parameter int DEPTH     = 16,
  parameter int ARR_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,     // synchronous, active-low
  input  logic                        wen,
  input  logic                        wsel_b,
  input  logic [$clog2(SIZE)-1:0]     wlane,
  input  logic [DATAWIDTH-1:0]        data_in,
  input  logic                        start,
  input  logic [$clog2(DEPTH+1)-1:0]  k_len,
  output logic [SIZE*DATAWIDTH-1:0]   a_out,
  output logic [SIZE*DATAWIDTH-1:0]   b_out,
  output logic                        load_en,
  output logic                        mult_en,
  output logic                        acc_en,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        overflow
);

  localparam int LANE_W    = $clog2(SIZE);
  localparam int KW        = $clog2(DEPTH + 1);
  localparam int DRAIN_CYC = drain_cycles(SIZE, ARR_LAT);
  localparam int DCW       = $clog2(2 * SIZE + ARR_LAT + 1);

  // ---------------------------------------------------------------- signals
  feeder_state_t r_state;
  feeder_state_t w_next;

  logic [KW-1:0]  r_kcnt;
  logic [DCW-1:0] r_dcnt;
  logic           r_err;
  logic           r_ovf;
  logic           r_pop_vld;

  logic           w_load_en;
  logic           w_mac_en;
  logic           w_busy;
  logic           w_done;
  logic           w_pop;
  logic           w_start_bad;
  logic           w_can_start;
  logic           w_ovf_hit;

  logic [SIZE-1:0]      w_wen_a;
  logic [SIZE-1:0]      w_wen_b;
  logic [SIZE-1:0]      w_full_a;
  logic [SIZE-1:0]      w_full_b;
  logic [SIZE-1:0]      w_empty_a;
  logic [SIZE-1:0]      w_empty_b;
  logic [KW-1:0]        w_count_a [SIZE];
  logic [KW-1:0]        w_count_b [SIZE];
  logic [DATAWIDTH-1:0] w_q_a     [SIZE];
  logic [DATAWIDTH-1:0] w_q_b     [SIZE];
  logic [DATAWIDTH-1:0] w_a_head  [SIZE];
  logic [DATAWIDTH-1:0] w_b_head  [SIZE];

  // ------------------------------------------------------- per-lane datapath
  for (genvar l = 0; l < SIZE; l++) begin : g_lane

    // A write with an out-of-range lane index matches no lane and vanishes.
    assign w_wen_a[l] = wen && !wsel_b && (wlane == LANE_W'(l));
    assign w_wen_b[l] = wen &&  wsel_b && (wlane == LANE_W'(l));

    tensor_feeder_sv_lane_fifo #(
      .WIDTH (DATAWIDTH),
      .DEPTH (DEPTH)
    ) u_fifo_a (
      .clk     (clk),
      .reset   (reset),
      .i_wen   (w_wen_a[l]),
      .i_ren   (w_pop),
      .i_data  (data_in),
      .o_q     (w_q_a[l]),
      .o_count (w_count_a[l]),
      .o_full  (w_full_a[l]),
      .o_empty (w_empty_a[l])
    );

    tensor_feeder_sv_lane_fifo #(
      .WIDTH (DATAWIDTH),
      .DEPTH (DEPTH)
    ) u_fifo_b (
      .clk     (clk),
      .reset   (reset),
      .i_wen   (w_wen_b[l]),
      .i_ren   (w_pop),
      .i_data  (data_in),
      .o_q     (w_q_b[l]),
      .o_count (w_count_b[l]),
      .o_full  (w_full_b[l]),
      .o_empty (w_empty_b[l])
    );

    // FIFO q holds its last value between pops; mask it so bubbles are zero.
    assign w_a_head[l] = r_pop_vld ? w_q_a[l] : '0;
    assign w_b_head[l] = r_pop_vld ? w_q_b[l] : '0;

    if (l == 0) begin : g_direct
      assign a_out[0 +: DATAWIDTH] = w_a_head[0];
      assign b_out[0 +: DATAWIDTH] = w_b_head[0];
    end else begin : g_skew
      logic [DATAWIDTH-1:0] r_a_pipe [l];
      logic [DATAWIDTH-1:0] r_b_pipe [l];

      // Lane l is delayed by l registers so operands meet on the diagonal.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int s = 0; s < l; s++) begin
            r_a_pipe[s] <= '0;
            r_b_pipe[s] <= '0;
          end
        end else begin
          r_a_pipe[0] <= w_a_head[l];
          r_b_pipe[0] <= w_b_head[l];
          for (int s = 1; s < l; s++) begin
            r_a_pipe[s] <= r_a_pipe[s-1];
            r_b_pipe[s] <= r_b_pipe[s-1];
          end
        end
      end

      assign a_out[l*DATAWIDTH +: DATAWIDTH] = r_a_pipe[l-1];
      assign b_out[l*DATAWIDTH +: DATAWIDTH] = r_b_pipe[l-1];
    end
  end

  // Tile admission check and overflow detection across all lanes.
  always_comb begin
    w_can_start = (k_len != '0);
    w_ovf_hit   = 1'b0;
    for (int l = 0; l < SIZE; l++) begin
      if (w_empty_a[l] || w_empty_b[l] ||
          (w_count_a[l] < k_len) || (w_count_b[l] < k_len)) begin
        w_can_start = 1'b0;
      end
      if ((w_wen_a[l] && w_full_a[l]) || (w_wen_b[l] && w_full_b[l])) begin
        w_ovf_hit = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next      = r_state;
    w_load_en   = 1'b0;
    w_mac_en    = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_pop       = 1'b0;
    w_start_bad = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          if (w_can_start) begin
            w_next = LOAD;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      LOAD: begin
        w_load_en = 1'b1;
        w_next    = STREAM;
      end
      STREAM: begin
        w_mac_en = 1'b1;
        w_pop    = 1'b1;
        if (r_kcnt == KW'(1)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_mac_en = 1'b1;
        if (r_dcnt == DCW'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Stream / drain counters; k_len is captured on the accepting edge so the
  // tile length is the one that passed the occupancy check.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_kcnt <= '0;
      r_dcnt <= '0;
    end else begin
      if ((r_state == IDLE) && (w_next == LOAD)) begin
        r_kcnt <= k_len;
      end else if (r_state == STREAM) begin
        r_kcnt <= r_kcnt - KW'(1);
      end
      if ((r_state == STREAM) && (w_next == DRAIN)) begin
        r_dcnt <= DCW'(DRAIN_CYC);
      end else if (r_state == DRAIN) begin
        r_dcnt <= r_dcnt - DCW'(1);
      end
    end
  end

  // Status flags and the pop-valid marker that qualifies FIFO q data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_pop_vld <= 1'b0;
    end else begin
      r_err     <= w_start_bad;
      r_pop_vld <= w_pop;
      if (w_ovf_hit) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign load_en  = w_load_en;
  assign mult_en  = w_mac_en;
  assign acc_en   = w_mac_en;
  assign busy     = w_busy;
  assign done     = w_done;
  assign err      = r_err;
  assign overflow = r_ovf;

endmodule : tensor_feeder_sv
`default_nettype wire

// File: tb/tb_tensor_feeder_sv.sv
`default_nettype none
// ============================================================================
// Module   : tb_tensor_feeder_sv
// Brief    : Self-checking bench for tensor_feeder_sv (SIZE=4, DEPTH=16).
//            Per-lane FIFO model feeds a queue of expected per-cycle outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tensor_feeder_sv;

  localparam int W  = 14;
  localparam int S  = 4;
  localparam int D  = 16;
  localparam int AL = 1;
  localparam int DR = 2 * (S - 1) + AL;
  localparam int LW = 2;
  localparam int KW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           wen;
  logic           wsel_b;
  logic [LW-1:0]  wlane;
  logic [W-1:0]   data_in;
  logic           start;
  logic [KW-1:0]  k_len;
  logic [S*W-1:0] a_out;
  logic [S*W-1:0] b_out;
  logic           load_en, mult_en, acc_en, busy, done, err, overflow;

  always #5 clk = ~clk;

  tensor_feeder_sv #(
    .DATAWIDTH (W),
    .SIZE      (S),
    .DEPTH     (D),
    .ARR_LAT   (AL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wen      (wen),
    .wsel_b   (wsel_b),
    .wlane    (wlane),
    .data_in  (data_in),
    .start    (start),
    .k_len    (k_len),
    .a_out    (a_out),
    .b_out    (b_out),
    .load_en  (load_en),
    .mult_en  (mult_en),
    .acc_en   (acc_en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [S*W-1:0] a;
    logic [S*W-1:0] b;
    logic [6:0]     ctl;   // busy, load_en, mult_en, acc_en, done, err, overflow
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         exp_ovf = 1'b0;

  // Lane FIFO model: index 0..S-1 = A lanes, S..2S-1 = B lanes.
  logic [W-1:0] mm [2*S][64];
  int           hd [2*S];
  int           tl [2*S];
  logic [W-1:0] ta [S][D];
  logic [W-1:0] tb [S][D];
  logic [W-1:0] ah [64][S];
  logic [W-1:0] bh [64][S];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [6:0] ctl_now();
    return {busy, load_en, mult_en, acc_en, done, err, overflow};
  endfunction

  task automatic model_clear();
    for (int q = 0; q < 2*S; q++) begin
      hd[q] = 0;
      tl[q] = 0;
    end
    exp_ovf = 1'b0;
  endtask

  task automatic model_push(input int q, input logic [W-1:0] v);
    if (tl[q] - hd[q] < D) begin
      mm[q][tl[q]] = v;
      tl[q]++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic wr(input int q, input logic [W-1:0] v);
    wen     = 1'b1;
    wsel_b  = (q >= S);
    wlane   = LW'(q % S);
    data_in = v;
    model_push(q, v);
    step();
    wen = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},   64'(a_out),     64'(0));
    chk({tag, "_b"},   64'(b_out),     64'(0));
    chk({tag, "_ctl"}, 64'(ctl_now()), 64'(0));
  endtask

  // Drives one start request and checks every cycle of the resulting tile.
  // inj_e: edge at which a start pulse and a B lane 3 write are injected.
  // rst_e: edge at which reset is pulsed for one cycle.
  task automatic run_tile(input int k, input int inj_e, input int rst_e, input string tag);
    exp_t x;
    bit   ok;
    int   last;
    int   j;
    ok = (k != 0);
    for (int q = 0; q < 2*S; q++) if (tl[q] - hd[q] < k) ok = 1'b0;
    if (ok) begin
      for (int l = 0; l < S; l++) begin
        for (int m = 0; m < k; m++) begin
          ta[l][m] = mm[l][hd[l]];
          tb[l][m] = mm[S+l][hd[S+l]];
          hd[l]++;
          hd[S+l]++;
        end
      end
    end
    last = ok ? (3 + k + DR) : 2;
    for (int e = 1; e <= last; e++) begin
      x = '0;
      if (rst_e > 0 && e >= rst_e) begin
        x = '0;
      end else begin
        x.ctl[0] = exp_ovf;
        if (ok) begin
          for (int l = 0; l < S; l++) begin
            j = e - 3 - l;
            if (j >= 0 && j < k) begin
              x.a[l*W +: W] = ta[l][j];
              x.b[l*W +: W] = tb[l][j];
            end
          end
          x.ctl[6] = (e <= 2 + k + DR);
          x.ctl[5] = (e == 1);
          x.ctl[4] = (e >= 2) && (e <= 1 + k + DR);
          x.ctl[3] = x.ctl[4];
          x.ctl[2] = (e == 2 + k + DR);
        end else begin
          x.ctl[1] = (e == 1);
        end
      end
      exp_q.push_back(x);
    end
    k_len = KW'(k);
    for (int e = 0; e < 64; e++) begin
      for (int l = 0; l < S; l++) begin
        ah[e][l] = '0;
        bh[e][l] = '0;
      end
    end
    for (int e = 1; e <= last; e++) begin
      start = (e == 1) || (e == inj_e);
      reset = !(e == rst_e);
      if (e == inj_e) begin
        wen     = 1'b1;
        wsel_b  = 1'b1;
        wlane   = LW'(3);
        data_in = W'('h3AB);
        model_push(S + 3, W'('h3AB));
      end
      step();
      start = 1'b0;
      wen   = 1'b0;
      reset = 1'b1;
      for (int l = 0; l < S; l++) begin
        ah[e][l] = a_out[l*W +: W];
        bh[e][l] = b_out[l*W +: W];
      end
      if (exp_q.size() == 0) begin
        chk({tag, "_queue"}, 64'(0), 64'(1));
      end else begin
        x = exp_q.pop_front();
        chk({tag, "_a"},   64'(a_out),     64'(x.a));
        chk({tag, "_b"},   64'(b_out),     64'(x.b));
        chk({tag, "_ctl"}, 64'(ctl_now()), 64'(x.ctl));
      end
    end
    if (rst_e > 0) model_clear();
  endtask

  initial begin
    int acc;
    int v;
    reset   = 1'b0;
    wen     = 1'b0;
    wsel_b  = 1'b0;
    wlane   = '0;
    data_in = '0;
    start   = 1'b0;
    k_len   = '0;
    model_clear();
    step(); step();
    chk_zero("por");
    reset = 1'b1;

    // Reset after random writes empties everything.
    for (int n = 0; n < 6; n++) wr(int'($urandom_range(0, 2*S-1)), W'($urandom_range(1, 999)));
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk_zero("rst_hold");
    end
    model_clear();
    reset = 1'b1;
    run_tile(1, 0, 0, "rst_start_err");

    // Identity A, B = 1..16 row-major; A lane i = row i, B lane j = column j.
    for (int i = 0; i < S; i++) begin
      for (int m = 0; m < S; m++) begin
        wr(i, W'((i == m) ? 1 : 0));
        wr(S + i, W'(4 * m + i + 1));
      end
    end
    run_tile(4, 0, 0, "tile_ident");
    // Replay the captured skewed streams through an output-stationary array.
    for (int i = 0; i < S; i++) begin
      for (int c = 0; c < S; c++) begin
        acc = 0;
        for (int u = 0; u < 64; u++) begin
          v = u + c - i;
          if (v >= 0 && v < 64) acc += int'(ah[u][i]) * int'(bh[v][c]);
        end
        chk("array_result", 64'(acc), 64'(4 * i + c + 1));
      end
    end

    // k_len=5 while A lane 1 holds only 4 entries.
    for (int q = 0; q < 2*S; q++) begin
      for (int m = 0; m < ((q == 1) ? 4 : 5); m++) wr(q, W'(100 + q * 8 + m));
    end
    run_tile(5, 0, 0, "short_lane_err");

    // Same contents, k_len=4: start pulse and B lane 3 write during STREAM.
    run_tile(4, 3, 0, "stream_inject");

    // Top up to two entries per lane, then reset in the middle of DRAIN.
    wr(1, W'(300));
    wr(1, W'(301));
    for (int q = 0; q < 2*S; q++) if (q != 1 && q != 2*S-1) wr(q, W'(300 + q * 4));
    run_tile(2, 0, 9, "drain_reset");
    chk_zero("post_reset");

    // 17 writes into A lane 0: the last one is dropped and overflow sticks.
    for (int m = 0; m < 17; m++) wr(0, W'(200 + m));
    chk("ovf_sticky", 64'(overflow), 64'(1));
    for (int q = 1; q < 2*S; q++) begin
      for (int m = 0; m < D; m++) wr(q, W'(400 + q * 16 + m));
    end
    run_tile(16, 0, 0, "full_depth");
    run_tile(1, 0, 0, "dropped_17th");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_tensor_feeder_sv
`default_nettype wire
